// File: rtl/dmem_resp_pkg.sv
// Shared opcodes, port-state encoding and write-buffer entry layout for the
// dmem writeback responder.
package dmem_resp_pkg;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef enum logic [1:0] {
    P_IDLE,
    P_WRITE,
    P_READ
  } port_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dmem_writeback_responder_if.sv
// L2-facing writeback/fill bundle; master = L2 side, slave = responder side.
// Fill data and status are registered in the responder; no combinational paths.
interface dmem_writeback_responder_if #(
  parameter int WB_DEPTH = 4
);
  logic [6:0]                opcode_in;
  logic [31:0]               address_in;
  logic [31:0]               data_in;
  logic                      rd_en;
  logic [31:0]               rd_addr;
  logic                      rd_ready;
  logic                      rd_valid;
  logic [31:0]               data_to_L2;
  logic [$clog2(WB_DEPTH):0] wb_count;
  logic                      wb_full;
  logic                      overflow_err;

  modport master (
    output opcode_in, address_in, data_in, rd_en, rd_addr,
    input  rd_ready, rd_valid, data_to_L2, wb_count, wb_full, overflow_err
  );

  modport slave (
    input  opcode_in, address_in, data_in, rd_en, rd_addr,
    output rd_ready, rd_valid, data_to_L2, wb_count, wb_full, overflow_err
  );
endinterface

// File: rtl/dmem_writeback_responder_wb_fifo.sv
// Circular write buffer with registered count and a combinational newest-match
// lookup by full address; caller must never push when full without a pop.
module wb_fifo
  import dmem_resp_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  localparam int PTR_W = $clog2(WB_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  wb_entry_t        push_dat_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o,
  input  logic [31:0]      lookup_addr_i,
  output logic             hit_o,
  output logic [31:0]      hit_dat_o
);

  wb_entry_t        entries_q [WB_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      if (push_i) begin
        entries_q[tail_q] <= push_dat_i;
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (pop_i) head_q <= head_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk oldest to newest so the last hit is the newest matching entry.
  always_comb begin
    hit_o     = 1'b0;
    hit_dat_o = '0;
    idx       = head_q;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (i < int'(count_q) && entries_q[idx].addr == lookup_addr_i) begin
        hit_o     = 1'b1;
        hit_dat_o = entries_q[idx].data;
      end
    end
  end

  assign head_o  = entries_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(WB_DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dmem_writeback_responder.sv
// Captures L2 writebacks into a write buffer, drains them to a single-ported word
// array, and serves fills after RD_CYCLES array cycles with buffer forwarding.
module dmem_writeback_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int WB_DEPTH  = 4,
  parameter int WR_CYCLES = 4,
  parameter int RD_CYCLES = 3
) (
  input logic                      clk,
  input logic                      reset,
  dmem_writeback_responder_if.slave bus
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = $clog2(WB_DEPTH);
  localparam int CNT_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  port_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       prev_op_q;
  wb_entry_t        last_q, in_entry, head;
  logic             accept, push, pop, rd_done, rd_ready;
  logic             full, empty, hit;
  logic [PTR_W:0]   count;
  logic [31:0]      hit_dat, rd_result;
  logic             rd_pending_q, rd_valid_q, ovf_q;
  logic [31:0]      rd_addr_q, data_q;
  logic [31:0]      mem_q [DEPTH];
  logic             unused_hi_addr;

  // L2 holds its outputs after a writeback, so only a change re-arms capture.
  assign in_entry = '{addr: bus.address_in, data: bus.data_in};
  assign accept   = (bus.opcode_in == OP_STORE) &&
                    ((prev_op_q != OP_STORE) || (in_entry != last_q));
  assign push     = accept && (!full || pop);

  wb_fifo #(.WB_DEPTH(WB_DEPTH)) u_wb_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push),
    .push_dat_i    (in_entry),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty),
    .lookup_addr_i (rd_addr_q),
    .hit_o         (hit),
    .hit_dat_o     (hit_dat)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= P_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    rd_done = 1'b0;
    unique case (state_q)
      P_IDLE: begin
        if (full) begin
          state_d = P_WRITE;
          cnt_d   = CNT_W'(WR_CYCLES - 1);
        end else if (rd_pending_q) begin
          state_d = P_READ;
          cnt_d   = CNT_W'(RD_CYCLES - 1);
        end else if (!empty) begin
          state_d = P_WRITE;
          cnt_d   = CNT_W'(WR_CYCLES - 1);
        end
      end
      P_WRITE: begin
        if (cnt_q == '0) begin
          pop     = 1'b1;
          state_d = P_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      P_READ: begin
        if (cnt_q == '0) begin
          rd_done = 1'b1;
          state_d = P_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  assign rd_ready  = !rd_pending_q && (state_q != P_READ);
  assign rd_result = hit ? hit_dat : mem_q[rd_addr_q[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_op_q    <= '0;
      last_q       <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      data_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      prev_op_q  <= bus.opcode_in;
      rd_valid_q <= rd_done;
      if (accept) last_q <= in_entry;
      if (accept && full && !pop) ovf_q <= 1'b1;
      if (rd_done) begin
        data_q       <= rd_result;
        rd_pending_q <= 1'b0;
      end else if (bus.rd_en && rd_ready) begin
        rd_pending_q <= 1'b1;
        rd_addr_q    <= bus.rd_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (pop) begin
      mem_q[head.addr[IDX_W-1:0]] <= head.data;
    end
  end

  // Upper address bits only matter for forwarding, never for the array.
  assign unused_hi_addr = ^head.addr[31:IDX_W];

  assign bus.rd_ready     = rd_ready;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.data_to_L2   = data_q;
  assign bus.wb_count     = count;
  assign bus.wb_full      = full;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_dmem_writeback_responder.sv
// Bench for dmem_writeback_responder: directed corner cases, an overflow vector
// table, and random writeback/fill traffic against a word-array reference model.
module tb_dmem_writeback_responder;
  import dmem_resp_pkg::*;

  localparam int RD_CYCLES = 3;
  localparam int WB_DEPTH  = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  dmem_writeback_responder_if #(.WB_DEPTH(WB_DEPTH)) bus ();

  dmem_writeback_responder #(
    .DEPTH(1024), .WB_DEPTH(WB_DEPTH), .WR_CYCLES(4), .RD_CYCLES(RD_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_cnt;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] mref [1024];
  logic [31:0] pend [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.opcode_in  = '0;
    bus.address_in = '0;
    bus.data_in    = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) mref[i] = '0;
    pend.delete();
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (bus.wb_count != 0 && w < 300) begin
      step();
      w++;
    end
    chk("drain_in_time", 32'(w < 300), 32'd1);
  endtask

  // Called right after the acceptance edge; lat counts edges until rd_valid.
  task automatic wait_fill(output logic [31:0] d, output int lat, output logic rdy_low);
    lat     = 0;
    rdy_low = 1'b1;
    while (lat < 200) begin
      if (bus.rd_ready) rdy_low = 1'b0;
      step();
      lat++;
      if (bus.rd_valid) break;
    end
    d = bus.data_to_L2;
  endtask

  task automatic do_fill(input logic [31:0] a, output logic [31:0] d, output int lat,
                         output logic rdy_low);
    int w;
    w = 0;
    while (!bus.rd_ready && w < 200) begin
      step();
      w++;
    end
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    step();
    bus.rd_en = 1'b0;
    wait_fill(d, lat, rdy_low);
  endtask

  task automatic put_wb(input logic [31:0] a, input logic [31:0] d);
    bus.opcode_in  = OP_STORE;
    bus.address_in = a;
    bus.data_in    = d;
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    logic        rdy_low;
    int          maxc;
    total = 0;
    bad   = 0;

    vecs[0] = '{32'h100, 32'hA000_0000, 1, 1'b0, 1'b0};
    vecs[1] = '{32'h101, 32'hA000_0001, 2, 1'b0, 1'b0};
    vecs[2] = '{32'h102, 32'hA000_0002, 3, 1'b0, 1'b0};
    vecs[3] = '{32'h103, 32'hA000_0003, 4, 1'b1, 1'b0};
    vecs[4] = '{32'h104, 32'hA000_0004, 4, 1'b1, 1'b1};

    // Reset state and duplicate suppression of a held writeback.
    do_reset();
    chk("rst_rd_ready", 32'(bus.rd_ready), 32'd1);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_data", bus.data_to_L2, 32'd0);
    chk("rst_wb_count", 32'(bus.wb_count), 32'd0);
    chk("rst_wb_full", 32'(bus.wb_full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    put_wb(32'h30, 32'h1234_5678);
    maxc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (int'(bus.wb_count) > maxc) maxc = int'(bus.wb_count);
    end
    bus.opcode_in = '0;
    chk("hold_peak_count", 32'(maxc), 32'd1);
    wait_drain();
    do_fill(32'h30, d, lat, rdy_low);
    chk("hold_fill_data", d, 32'h1234_5678);

    // Drained writeback then fill: latency RD_CYCLES+1, one-cycle pulse, data held.
    put_wb(32'h20, 32'hDEAD_BEEF);
    step();
    bus.opcode_in = '0;
    wait_drain();
    do_fill(32'h20, d, lat, rdy_low);
    chk("fill_data", d, 32'hDEAD_BEEF);
    chk("fill_latency", 32'(lat), 32'(RD_CYCLES + 1));
    chk("fill_rdy_low", 32'(rdy_low), 32'd1);
    step();
    chk("fill_pulse_end", 32'(bus.rd_valid), 32'd0);
    chk("fill_data_held", bus.data_to_L2, 32'hDEAD_BEEF);
    chk("fill_rdy_back", 32'(bus.rd_ready), 32'd1);

    // Back-to-back writebacks to one address, immediate fill sees the newest.
    put_wb(32'h40, 32'h1);
    step();
    put_wb(32'h40, 32'h2);
    step();
    bus.opcode_in = '0;
    do_fill(32'h40, d, lat, rdy_low);
    chk("fwd_newest", d, 32'h2);

    // Overflow table: fifth writeback into a full buffer is dropped.
    do_reset();
    foreach (vecs[i]) begin
      put_wb(vecs[i].addr, vecs[i].data);
      step();
      chk($sformatf("ovf_cnt_%0d", i), 32'(bus.wb_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("ovf_full_%0d", i), 32'(bus.wb_full), 32'(vecs[i].exp_full));
      chk($sformatf("ovf_err_%0d", i), 32'(bus.overflow_err), 32'(vecs[i].exp_ovf));
    end
    bus.opcode_in = '0;
    wait_drain();
    chk("ovf_sticky", 32'(bus.overflow_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      do_fill(vecs[i].addr, d, lat, rdy_low);
      chk($sformatf("ovf_array_%0d", i), d, (i < 4) ? vecs[i].data : 32'd0);
    end
    chk("ovf_still_sticky", 32'(bus.overflow_err), 32'd1);

    // Full buffer with a fill: the head write finishes (pop 5 edges after the
    // first push), one idle edge arbitrates, then 3 read edges -> 6 edges total.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put_wb(32'h200 + 32'(i), 32'hB000_0000 + 32'(i));
      if (i == 3) begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = 32'h203;
      end
      step();
    end
    bus.rd_en     = 1'b0;
    bus.opcode_in = '0;
    chk("full_flag", 32'(bus.wb_full), 32'd1);
    wait_fill(d, lat, rdy_low);
    chk("full_fill_data", d, 32'hB000_0003);
    chk("full_fill_latency", 32'(lat), 32'd6);
    chk("full_fill_rdy_low", 32'(rdy_low), 32'd1);
    wait_drain();

    // Reset while the drain counter sits at 1: no array write, no rd_valid.
    do_reset();
    put_wb(32'h80, 32'h5555_AAAA);
    step();
    bus.opcode_in = '0;
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midwr_count", 32'(bus.wb_count), 32'd0);
    chk("midwr_rd_valid", 32'(bus.rd_valid), 32'd0);
    maxc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rd_valid) maxc++;
    end
    chk("midwr_no_valid", 32'(maxc), 32'd0);
    do_fill(32'h80, d, lat, rdy_low);
    chk("midwr_array", d, 32'd0);

    // Random traffic with aliased addresses against a plain word-array model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [31:0] hi;
      int          sel;
      int          w;
      logic        conflict;
      sel = int'($urandom_range(0, 2));
      hi  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h400 : 32'h1000_0400;
      a   = hi | 32'($urandom_range(16, 23));
      if ($urandom_range(0, 2) != 0) begin
        w = 0;
        while (bus.wb_count > 2 && w < 200) begin
          step();
          w++;
        end
        put_wb(a, $urandom);
        mref[a[9:0]] = bus.data_in;
        pend.push_back(a);
        for (int h = 0; h < int'($urandom_range(1, 3)); h++) step();
        if ($urandom_range(0, 1) == 0) begin
          bus.opcode_in = '0;
          step();
        end
      end else begin
        bus.opcode_in = '0;
        conflict = 1'b0;
        foreach (pend[i]) if (pend[i][9:0] == a[9:0] && pend[i] != a) conflict = 1'b1;
        if (conflict || bus.wb_count == 0) begin
          wait_drain();
          pend.delete();
        end
        do_fill(a, d, lat, rdy_low);
        chk($sformatf("rand_fill_%0d_%h", n, a), d, mref[a[9:0]]);
        chk($sformatf("rand_done_%0d", n), 32'(lat < 200), 32'd1);
      end
    end
    bus.opcode_in = '0;
    wait_drain();
    chk("rand_no_overflow", 32'(bus.overflow_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
